hive_gpio_debounce: RTL and testbench

HIVE_GPIO_DEBOUNCE -- requirements
Module: hive_gpio_debounce

---
 rtl/hive_gpio_debounce.sv | 86 ++++++++
 tb/tb_hive_gpio_debounce.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/hive_gpio_debounce.sv
// GPIO input conditioning: per-bit synchronizer, shared sample prescaler and
// tick-based debounce counters feeding the GPIO register's gpio_i.
module hive_gpio_debounce #(
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TICK_DIV    = 1000,
  parameter int STABLE_CNT  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] pin_i,
  input  logic [DATA_W-1:0] evt_clr_i,
  output logic [DATA_W-1:0] db_o,
  output logic [DATA_W-1:0] rise_o,
  output logic [DATA_W-1:0] fall_o,
  output logic [DATA_W-1:0] evt_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_CNT) + 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(STABLE_CNT - 1);

  logic [DATA_W-1:0] sync_q [SYNC_STAGES];
  logic [DATA_W-1:0] sync;
  logic [PW-1:0]     presc_q;
  logic              tick;
  logic [CW-1:0]     cnt_q [DATA_W];
  logic [DATA_W-1:0] accept;

  // Only the last synchronizer stage is ever looked at downstream.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= pin_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];
  assign tick = (presc_q == PRESC_MAX);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) presc_q <= '0;
    else if (tick) presc_q <= '0;
    else presc_q <= presc_q + PW'(1);
  end

  // A bit is accepted on the tick where it has already differed for STABLE_CNT-1 ticks.
  always_comb begin
    accept = '0;
    for (int b = 0; b < DATA_W; b++)
      accept[b] = (sync[b] != db_o[b]) && tick && (cnt_q[b] == CNT_MAX);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int b = 0; b < DATA_W; b++) cnt_q[b] <= '0;
    end else begin
      for (int b = 0; b < DATA_W; b++) begin
        if (sync[b] == db_o[b]) cnt_q[b] <= '0;
        else if (tick) begin
          if (cnt_q[b] == CNT_MAX) cnt_q[b] <= '0;
          else cnt_q[b] <= cnt_q[b] + CW'(1);
        end
      end
    end
  end

  // Edge flags are taken from the registered pulses, so a set always beats a clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      db_o   <= '0;
      rise_o <= '0;
      fall_o <= '0;
      evt_o  <= '0;
    end else begin
      db_o   <= db_o ^ accept;
      rise_o <= accept & sync;
      fall_o <= accept & ~sync;
      evt_o  <= (evt_o & ~evt_clr_i) | rise_o | fall_o;
    end
  end

endmodule

// File: tb/tb_hive_gpio_debounce.sv
// Bench for hive_gpio_debounce: a fast (TICK_DIV=1) and a prescaled (TICK_DIV=4)
// instance share one stimulus stream and are checked against a rule-level model.
module tb_hive_gpio_debounce;

  localparam int TD_FAST = 1, SC_FAST = 3;
  localparam int TD_SLOW = 4, SC_SLOW = 2;

  logic        clk, rst;
  logic [31:0] pin, clr;
  logic [31:0] db_a, rise_a, fall_a, evt_a;
  logic [31:0] db_b, rise_b, fall_b, evt_b;
  int          vectors, miscompares;
  bit          cmp_on;

  logic [31:0] m_sync [2][2];
  logic [31:0] m_db [2], m_rise [2], m_fall [2], m_evt [2];
  int          m_run [2][32];
  int          m_pre [2];

  hive_gpio_debounce #(.DATA_W(32), .SYNC_STAGES(2), .TICK_DIV(TD_FAST), .STABLE_CNT(SC_FAST)) dut_fast (
    .clk_i(clk), .rst_i(rst), .pin_i(pin), .evt_clr_i(clr),
    .db_o(db_a), .rise_o(rise_a), .fall_o(fall_a), .evt_o(evt_a)
  );

  hive_gpio_debounce #(.DATA_W(32), .SYNC_STAGES(2), .TICK_DIV(TD_SLOW), .STABLE_CNT(SC_SLOW)) dut_slow (
    .clk_i(clk), .rst_i(rst), .pin_i(pin), .evt_clr_i(clr),
    .db_o(db_b), .rise_o(rise_b), .fall_o(fall_b), .evt_o(evt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] p, input logic [31:0] c, input int n);
    pin = p;
    clr = c;
    repeat (n) @(negedge clk);
  endtask

  // Model: a level is accepted once it has been seen differing from db on
  // STABLE_CNT sample ticks with no cycle of agreement in between.
  task automatic modelStep(input int k);
    int td, sc;
    bit t;
    logic [31:0] s, nd, r, f;
    td = (k == 0) ? TD_FAST : TD_SLOW;
    sc = (k == 0) ? SC_FAST : SC_SLOW;
    t  = (m_pre[k] == td - 1);
    s  = m_sync[k][1];
    nd = m_db[k];
    r  = '0;
    f  = '0;
    for (int b = 0; b < 32; b++) begin
      if (s[b] == m_db[k][b]) m_run[k][b] = 0;
      else if (t) begin
        m_run[k][b]++;
        if (m_run[k][b] >= sc) begin
          nd[b] = s[b];
          r[b]  = s[b];
          f[b]  = ~s[b];
          m_run[k][b] = 0;
        end
      end
    end
    m_evt[k]    = (m_evt[k] & ~clr) | m_rise[k] | m_fall[k];
    m_rise[k]   = r;
    m_fall[k]   = f;
    m_db[k]     = nd;
    m_pre[k]    = t ? 0 : m_pre[k] + 1;
    m_sync[k][1] = m_sync[k][0];
    m_sync[k][0] = pin;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_sync[k][0] = '0; m_sync[k][1] = '0;
        m_db[k] = '0; m_rise[k] = '0; m_fall[k] = '0; m_evt[k] = '0;
        m_pre[k] = 0;
        for (int b = 0; b < 32; b++) m_run[k][b] = 0;
      end
    end else begin
      modelStep(0);
      modelStep(1);
    end
  end

  always @(negedge clk) begin
    if (!rst && cmp_on) begin
      checkOutput("fast.db",   db_a,   m_db[0]);
      checkOutput("fast.rise", rise_a, m_rise[0]);
      checkOutput("fast.fall", fall_a, m_fall[0]);
      checkOutput("fast.evt",  evt_a,  m_evt[0]);
      checkOutput("slow.db",   db_b,   m_db[1]);
      checkOutput("slow.rise", rise_b, m_rise[1]);
      checkOutput("slow.fall", fall_b, m_fall[1]);
      checkOutput("slow.evt",  evt_b,  m_evt[1]);
    end
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    cmp_on = 1'b0;
    rst = 1'b1;
    pin = '0;
    clr = '0;
    #3;
    checkOutput("reset.db_fast",  db_a,  32'h0);
    checkOutput("reset.evt_fast", evt_a, 32'h0);
    checkOutput("reset.db_slow",  db_b,  32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cmp_on = 1'b1;

    // Clean rise on bits 0/1: fast accepts at edge 5, slow at its 2nd tick (edge 8).
    applyStimulus(32'h3, 32'h0, 4);
    checkOutput("rise.db0_edge4", 32'(db_a[0]), 32'd0);
    applyStimulus(32'h3, 32'h0, 1);
    checkOutput("rise.db0_edge5",   32'(db_a[0]),   32'd1);
    checkOutput("rise.pulse_edge5", 32'(rise_a[0]), 32'd1);
    applyStimulus(32'h3, 32'h0, 1);
    checkOutput("rise.pulse_edge6", 32'(rise_a[0]), 32'd0);
    checkOutput("rise.evt_edge6",   32'(evt_a[0]),  32'd1);
    applyStimulus(32'h3, 32'h0, 1);
    checkOutput("presc.db1_edge7", 32'(db_b[1]), 32'd0);
    applyStimulus(32'h3, 32'h0, 1);
    checkOutput("presc.db1_edge8",   32'(db_b[1]),   32'd1);
    checkOutput("presc.rise1_edge8", 32'(rise_b[1]), 32'd1);

    // Two-cycle glitch on bit 3 must leave no trace.
    applyStimulus(32'hB, 32'h0, 2);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(32'h3, 32'h0, 1);
      checkOutput("glitch.fast", {29'b0, db_a[3], rise_a[3], evt_a[3]}, 32'h0);
      checkOutput("glitch.slow", {29'b0, db_b[3], rise_b[3], evt_b[3]}, 32'h0);
    end

    // Clear arriving with the fall pulse loses; the next clear wins.
    applyStimulus(32'h7, 32'h0, 12);
    checkOutput("clr.evt2_set", 32'(evt_a[2]), 32'd1);
    applyStimulus(32'h3, 32'h0, 5);
    checkOutput("clr.fall2", 32'(fall_a[2]), 32'd1);
    applyStimulus(32'h3, 32'h4, 1);
    checkOutput("clr.collide", 32'(evt_a[2]), 32'd1);
    applyStimulus(32'h3, 32'h4, 1);
    checkOutput("clr.cleared", 32'(evt_a[2]), 32'd0);

    // Asynchronous reset with bit 0 two ticks into its count.
    applyStimulus(32'h2, 32'h0, 15);
    applyStimulus(32'h3, 32'h0, 4);
    checkOutput("midrst.db_before", db_a, 32'h2);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst.fast", db_a | rise_a | fall_a | evt_a, 32'h0);
    checkOutput("midrst.slow", db_b | rise_b | fall_b | evt_b, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(32'h3, 32'h0, 4);
    checkOutput("midrst.db_edge4", db_a, 32'h0);
    applyStimulus(32'h3, 32'h0, 1);
    checkOutput("midrst.db_edge5",   db_a,   32'h3);
    checkOutput("midrst.rise_edge5", rise_a, 32'h3);
    applyStimulus(32'h3, 32'h0, 1);
    checkOutput("midrst.evt_edge6", evt_a, 32'h3);

    // Wide pattern: every bit independent, no falls from a zero start.
    applyStimulus(32'h0, 32'h0, 15);
    applyStimulus(32'hA5A5_5A5A, 32'h0, 4);
    checkOutput("indep.db_edge4", db_a, 32'h0);
    applyStimulus(32'hA5A5_5A5A, 32'h0, 1);
    checkOutput("indep.db_edge5",   db_a,   32'hA5A5_5A5A);
    checkOutput("indep.rise_edge5", rise_a, 32'hA5A5_5A5A);
    checkOutput("indep.fall_edge5", fall_a, 32'h0);
    applyStimulus(32'hA5A5_5A5A, 32'h0, 1);
    checkOutput("indep.rise_edge6", rise_a, 32'h0);
    applyStimulus(32'hA5A5_5A5A, 32'h0, 12);
    checkOutput("indep.db_slow", db_b, 32'hA5A5_5A5A);

    applyStimulus(32'hA5A5_5A5A, 32'h0, 3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
